// File: rtl/rf_multiport_clr.sv
// rf_multiport_clr
//   Datapath register file with one synchronous write port and NUM_RD
//   combinational read ports. Optional same-cycle write-to-read bypass and
//   optional hardwired-zero entry 0. A soft-clear sequencer walks every entry
//   to zero, one per cycle, and holds off writes via wready while it runs.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous reset, active low
//   clr_req   in   start soft clear (only looked at while idle)
//   clr_busy  out  high while the clear sequence runs
//   we        in   write request
//   waddr     in   write address [AW-1:0]
//   wdata     in   write data [WIDTH-1:0]
//   wready    out  write accepted this cycle (write occurs on we & wready)
//   raddr     in   packed read addresses, port k = raddr[k*AW +: AW]
//   rdata     out  packed read data, port k = rdata[k*WIDTH +: WIDTH]
//
// state   | meaning
// S_IDLE  | normal operation, writes accepted, clr_req sampled
// S_CLEAR | zeroing mem[cnt] each cycle, writes stalled

module rf_multiport_clr #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 8,
   parameter int NUM_RD   = 2,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr_req,
   output logic                      clr_busy,
   input  logic                      we,
   input  logic [AW-1:0]             waddr,
   input  logic [WIDTH-1:0]          wdata,
   output logic                      wready,
   input  logic [NUM_RD*AW-1:0]      raddr,
   output logic [NUM_RD*WIDTH-1:0]   rdata
);

   localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     cnt, cnt_nxt;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic              wr_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (clr_req) begin
               state_nxt = S_CLEAR;
               cnt_nxt   = '0;
            end
         end
         S_CLEAR: begin
            cnt_nxt = cnt + AW'(1);
            if (cnt == CNT_LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // wready is gated by rst_n so nothing is accepted or bypassed while the
   // block is held in reset, even though the state register already says idle.
   always_comb begin
      clr_busy = (state == S_CLEAR);
      wready   = (state == S_IDLE) && rst_n;
   end

   // Entry 0 is never written when it is hardwired to zero; this also keeps
   // the bypass from forwarding to address 0.
   assign wr_en = we && wready && !(ZERO_REG && (waddr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == S_CLEAR) begin
         mem[cnt] <= '0;
      end else if (wr_en) begin
         mem[waddr] <= wdata;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic          bypass_hit;
      logic          zero_hit;

      assign ra         = raddr[k*AW +: AW];
      assign bypass_hit = BYPASS && wr_en && (waddr == ra);
      assign zero_hit   = ZERO_REG && (ra == '0);
      assign rdata[k*WIDTH +: WIDTH] = zero_hit   ? '0 :
                                       bypass_hit ? wdata :
                                                    mem[ra];
   end

endmodule

// File: tb/tb_rf_multiport_clr.sv
module tb_rf_multiport_clr;

   localparam int WIDTH  = 64;
   localparam int DEPTH  = 8;
   localparam int NUM_RD = 2;
   localparam int AW     = 3;

   logic                    clk;
   logic                    rst_n;
   logic                    clr_req;
   logic                    we;
   logic [AW-1:0]           waddr;
   logic [WIDTH-1:0]        wdata;
   logic [NUM_RD*AW-1:0]    raddr;

   // dut_a: BYPASS=1, dut_nb: BYPASS=0, dut_z: BYPASS=1 + ZERO_REG=1
   logic                    busy_a, busy_nb, busy_z;
   logic                    wrdy_a, wrdy_nb, wrdy_z;
   logic [NUM_RD*WIDTH-1:0] rd_a, rd_nb, rd_z;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] exp;

   rf_multiport_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy_a), .we(we), .waddr(waddr),
      .wdata(wdata), .wready(wrdy_a), .raddr(raddr), .rdata(rd_a));

   rf_multiport_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy_nb), .we(we), .waddr(waddr),
      .wdata(wdata), .wready(wrdy_nb), .raddr(raddr), .rdata(rd_nb));

   rf_multiport_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_z (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(busy_z), .we(we), .waddr(waddr),
      .wdata(wdata), .wready(wrdy_z), .raddr(raddr), .rdata(rd_z));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [WIDTH-1:0] port(input logic [NUM_RD*WIDTH-1:0] bus, input int k);
      return bus[k*WIDTH +: WIDTH];
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      raddr = {a1, a0};
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr_req = 1'b0; we = 1'b1; waddr = 3'd1; wdata = 64'hFFFF; set_rd(3'd1, 3'd0);
      repeat (2) cyc();
      n_checks++;
      if (wrdy_a !== 1'b0) begin n_fail++; $display("FAIL reset_wready: got %b want 0", wrdy_a); end
      n_checks++;
      if (busy_a !== 1'b0 || busy_nb !== 1'b0 || busy_z !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b%b%b want 000", busy_a, busy_nb, busy_z);
      end
      n_checks++;
      if (rd_a !== '0 || rd_nb !== '0 || rd_z !== '0) begin
         n_fail++; $display("FAIL reset_rdata: got %h want 0", rd_a);
      end
      we = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_write_read();
      we = 1'b1; waddr = 3'd3; wdata = 64'hDEAD_BEEF; set_rd(3'd3, 3'd3);
      exp_q.push_back(64'hDEAD_BEEF);
      exp_q.push_back(64'hDEAD_BEEF);
      exp_q.push_back(64'hDEAD_BEEF);
      cyc();
      we = 1'b0;
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_a, 0) !== exp) begin n_fail++; $display("FAIL wr_rd_p0: got %h want %h", port(rd_a, 0), exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_a, 1) !== exp) begin n_fail++; $display("FAIL wr_rd_p1: got %h want %h", port(rd_a, 1), exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_nb, 1) !== exp) begin n_fail++; $display("FAIL wr_rd_nb_p1: got %h want %h", port(rd_nb, 1), exp); end
   endtask

   task automatic test_bypass();
      we = 1'b1; waddr = 3'd5; wdata = 64'h1234; set_rd(3'd5, 3'd3);
      exp_q.push_back(64'h1234);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'hDEAD_BEEF);
      exp_q.push_back(64'h1234);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_a, 0) !== exp) begin n_fail++; $display("FAIL bypass_hit: got %h want %h", port(rd_a, 0), exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_nb, 0) !== exp) begin n_fail++; $display("FAIL nobypass_old: got %h want %h", port(rd_nb, 0), exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_a, 1) !== exp) begin n_fail++; $display("FAIL bypass_other_port: got %h want %h", port(rd_a, 1), exp); end
      cyc();
      we = 1'b0;
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_nb, 0) !== exp) begin n_fail++; $display("FAIL nobypass_next: got %h want %h", port(rd_nb, 0), exp); end
   endtask

   task automatic test_clear();
      int  busy_cnt;
      bit  wr_seen;
      for (int i = 0; i < DEPTH - 1; i++) begin
         we = 1'b1; waddr = AW'(i); wdata = 64'h11 * i;
         cyc();
      end
      // write to entry 7 in the same cycle as the clear request: still committed
      clr_req = 1'b1; we = 1'b1; waddr = 3'd7; wdata = 64'h77;
      cyc();
      clr_req = 1'b0; we = 1'b0; set_rd(3'd6, 3'd7);
      exp_q.push_back(64'h66);
      exp_q.push_back(64'h77);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h77);
      #1;
      busy_cnt = 0; wr_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!busy_a) break;
         busy_cnt++;
         if (wrdy_a !== 1'b0) wr_seen = 1'b1;
         if (i == 3) begin
            exp = exp_q.pop_front(); n_checks++;
            if (port(rd_nb, 0) !== exp) begin n_fail++; $display("FAIL mid_clear_a6: got %h want %h", port(rd_nb, 0), exp); end
            exp = exp_q.pop_front(); n_checks++;
            if (port(rd_nb, 1) !== exp) begin n_fail++; $display("FAIL mid_clear_a7: got %h want %h", port(rd_nb, 1), exp); end
         end
         if (i == 7) begin
            exp = exp_q.pop_front(); n_checks++;
            if (port(rd_a, 0) !== exp) begin n_fail++; $display("FAIL late_clear_a6: got %h want %h", port(rd_a, 0), exp); end
            exp = exp_q.pop_front(); n_checks++;
            if (port(rd_a, 1) !== exp) begin n_fail++; $display("FAIL last_clear_a7: got %h want %h", port(rd_a, 1), exp); end
         end
         cyc();
      end
      n_checks++;
      if (busy_cnt != DEPTH) begin n_fail++; $display("FAIL clear_len: got %0d cycles want %0d", busy_cnt, DEPTH); end
      n_checks++;
      if (wr_seen) begin n_fail++; $display("FAIL clear_wready: got wready=1 during clear want 0"); end
      n_checks++;
      if (wrdy_a !== 1'b1) begin n_fail++; $display("FAIL post_clear_wready: got %b want 1", wrdy_a); end
      for (int a = 0; a < DEPTH; a += 2) begin
         set_rd(AW'(a), AW'(a + 1));
         #1;
         n_checks++;
         if (rd_a !== '0 || rd_nb !== '0 || rd_z !== '0) begin
            n_fail++; $display("FAIL post_clear_zero a%0d: got %h want 0", a, rd_nb);
         end
      end
      cyc();
   endtask

   task automatic test_hold_write();
      int busy_cnt;
      bit leak;
      clr_req = 1'b1; we = 1'b0;
      cyc();
      clr_req = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 64'hAA; set_rd(3'd2, 3'd2);
      exp_q.push_back(64'hAA);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'hAA);
      exp_q.push_back(64'hAA);
      #1;
      busy_cnt = 0; leak = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!busy_a) break;
         busy_cnt++;
         if (port(rd_a, 0) !== 64'h0 || port(rd_nb, 0) !== 64'h0) leak = 1'b1;
         cyc();
      end
      n_checks++;
      if (busy_cnt != DEPTH) begin n_fail++; $display("FAIL hold_clear_len: got %0d want %0d", busy_cnt, DEPTH); end
      n_checks++;
      if (leak) begin n_fail++; $display("FAIL hold_no_write: got write data visible during clear want 0"); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_a, 0) !== exp) begin n_fail++; $display("FAIL hold_first_idle_bypass: got %h want %h", port(rd_a, 0), exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_nb, 0) !== exp) begin n_fail++; $display("FAIL hold_first_idle_nb: got %h want %h", port(rd_nb, 0), exp); end
      cyc();
      we = 1'b0;
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_nb, 0) !== exp) begin n_fail++; $display("FAIL hold_commit_nb: got %h want %h", port(rd_nb, 0), exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_z, 1) !== exp) begin n_fail++; $display("FAIL hold_commit_z: got %h want %h", port(rd_z, 1), exp); end
   endtask

   task automatic test_zero_reg();
      we = 1'b1; waddr = 3'd0; wdata = 64'hFFFF; set_rd(3'd0, 3'd1);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'hFFFF);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'hFFFF);
      exp_q.push_back(64'h5555);
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_z, 0) !== exp) begin n_fail++; $display("FAIL zero_bypass: got %h want %h", port(rd_z, 0), exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_a, 0) !== exp) begin n_fail++; $display("FAIL nonzero_bypass: got %h want %h", port(rd_a, 0), exp); end
      cyc();
      waddr = 3'd1; wdata = 64'h5555;
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_z, 0) !== exp) begin n_fail++; $display("FAIL zero_stored: got %h want %h", port(rd_z, 0), exp); end
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_nb, 0) !== exp) begin n_fail++; $display("FAIL nonzero_stored: got %h want %h", port(rd_nb, 0), exp); end
      cyc();
      we = 1'b0;
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (port(rd_z, 1) !== exp) begin n_fail++; $display("FAIL zero_addr1: got %h want %h", port(rd_z, 1), exp); end
   endtask

   task automatic test_reset_mid_clear();
      we = 1'b1; waddr = 3'd4; wdata = 64'h44;
      cyc();
      we = 1'b0; clr_req = 1'b1;
      cyc();
      clr_req = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b0; we = 1'b1; waddr = 3'd4; wdata = 64'h99; set_rd(3'd4, 3'd5);
      #1;
      n_checks++;
      if (busy_a !== 1'b0 || wrdy_a !== 1'b0) begin
         n_fail++; $display("FAIL abort_ctrl: got busy=%b wready=%b want 0 0", busy_a, wrdy_a);
      end
      n_checks++;
      if (rd_a !== '0 || rd_z !== '0) begin n_fail++; $display("FAIL abort_rdata: got %h want 0", rd_a); end
      #2;
      rst_n = 1'b1; we = 1'b0;
      #1;
      n_checks++;
      if (busy_a !== 1'b0 || wrdy_a !== 1'b1) begin
         n_fail++; $display("FAIL abort_release: got busy=%b wready=%b want 0 1", busy_a, wrdy_a);
      end
      cyc();
      n_checks++;
      if (busy_a !== 1'b0 || busy_nb !== 1'b0 || wrdy_nb !== 1'b1) begin
         n_fail++; $display("FAIL abort_no_residual: got busy=%b wready=%b want 0 1", busy_a, wrdy_nb);
      end
      n_checks++;
      if (port(rd_nb, 0) !== 64'h0) begin n_fail++; $display("FAIL abort_mem: got %h want 0", port(rd_nb, 0)); end
   endtask

   initial begin
      rst_n = 1'b0; clr_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
      test_reset();
      test_write_read();
      test_bypass();
      test_clear();
      test_hold_write();
      test_zero_reg();
      test_reset_mid_clear();
      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
